// File: rtl/paper_processor_gen_pkg.sv
// Shared types and instruction-field helpers for the parametrised paper processor.
// Instruction layout, MSB first: op[1:0] | reg select | jump address.
package paper_processor_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_JZ   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    function automatic logic [1:0] instr_op(input logic [31:0] instr, input int unsigned instr_w);
        logic [31:0] sh;
        sh = instr >> (instr_w - 32'd2);
        return sh[1:0];
    endfunction

    function automatic logic [31:0] instr_reg(input logic [31:0] instr, input int unsigned pc_w,
                                              input int unsigned rsel_w);
        return (instr >> pc_w) & ((32'd1 << rsel_w) - 32'd1);
    endfunction

    function automatic logic [31:0] instr_addr(input logic [31:0] instr, input int unsigned pc_w);
        return instr & ((32'd1 << pc_w) - 32'd1);
    endfunction

endpackage

// File: rtl/paper_processor_gen_if.sv
// Control, program-load, register-access and status bundle of the paper processor.
interface paper_processor_gen_if #(
    parameter int REG_W     = 4,
    parameter int NUM_REGS  = 4,
    parameter int PC_W      = 4,
    parameter int MAX_STEPS = 255
);
    localparam int RSEL_W  = $clog2(NUM_REGS);
    localparam int INSTR_W = 2 + RSEL_W + PC_W;
    localparam int SC_W    = $clog2(MAX_STEPS + 1);

    logic               start;
    logic               busy;
    logic               done;
    logic               timeout;
    logic               prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               reg_we;
    logic [RSEL_W-1:0]  reg_sel;
    logic [REG_W-1:0]   reg_wdata;
    logic [REG_W-1:0]   reg_rdata;
    logic [PC_W-1:0]    pc;
    logic [1:0]         state;
    logic [INSTR_W-1:0] instruction;
    logic [SC_W-1:0]    step_count;

    modport master (
        output start, prog_we, prog_addr, prog_data, reg_we, reg_sel, reg_wdata,
        input  busy, done, timeout, reg_rdata, pc, state, instruction, step_count
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data, reg_we, reg_sel, reg_wdata,
        output busy, done, timeout, reg_rdata, pc, state, instruction, step_count
    );

endinterface

// File: rtl/paper_processor_gen_regfile.sv
// Data register file: preload write, increment / saturating-decrement port,
// per-register zero flags and combinational readback.
module paper_processor_gen_regfile #(
    parameter  int REG_W    = 4,
    parameter  int NUM_REGS = 4,
    localparam int RSEL_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                we_i,
    input  logic [RSEL_W-1:0]   wsel_i,
    input  logic [REG_W-1:0]    wdata_i,
    input  logic                op_en_i,
    input  logic                op_dec_i,
    input  logic [RSEL_W-1:0]   op_sel_i,
    input  logic [RSEL_W-1:0]   rsel_i,
    output logic [REG_W-1:0]    rdata_o,
    output logic [NUM_REGS-1:0] zero_o
);

    logic [REG_W-1:0] regs_q [NUM_REGS];
    logic [REG_W-1:0] cur;
    logic [REG_W-1:0] op_val_d;

    always_comb begin
        cur = regs_q[op_sel_i];
        if (op_dec_i) begin
            op_val_d = (cur == '0) ? cur : cur - REG_W'(1);
        end else begin
            op_val_d = cur + REG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clk_en) begin
            if (we_i) begin
                regs_q[wsel_i] <= wdata_i;
            end else if (op_en_i) begin
                regs_q[op_sel_i] <= op_val_d;
            end
        end
    end

    always_comb begin
        zero_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            zero_o[i] = (regs_q[i] == '0);
        end
    end

    assign rdata_o = regs_q[rsel_i];

endmodule

// File: rtl/paper_processor_gen.sv
// Parametrised paper processor: INC/DEC/JZ/HALT over a register file, with a writable
// program store, start/busy/done handshake and a per-run step limit.
module paper_processor_gen
    import paper_processor_gen_pkg::*;
#(
    parameter int REG_W     = 4,
    parameter int NUM_REGS  = 4,
    parameter int PC_W      = 4,
    parameter int MAX_STEPS = 255
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  clk_en,
    paper_processor_gen_if.slave bus
);

    localparam int RSEL_W  = $clog2(NUM_REGS);
    localparam int INSTR_W = 2 + RSEL_W + PC_W;
    localparam int SC_W    = $clog2(MAX_STEPS + 1);
    localparam int DEPTH   = 2 ** PC_W;

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pc_inc_d;
    logic [PC_W-1:0]    addr_d;
    logic [INSTR_W-1:0] instr_q;
    logic [SC_W-1:0]    step_q;
    logic [SC_W-1:0]    step_d;
    logic               timeout_q;
    logic [1:0]         op_d;
    logic [RSEL_W-1:0]  rsel_d;
    logic [NUM_REGS-1:0] zero;
    logic [REG_W-1:0]   rdata;
    logic               cfg_ok;
    logic               reg_op_en;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Loads and run requests are only honoured while the core is parked.
    assign cfg_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // No reset on the store so a loaded program survives a reset.
    always_ff @(posedge clk) begin
        if (!reset && clk_en && bus.prog_we && cfg_ok) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        op_d     = instr_op(32'(instr_q), INSTR_W);
        rsel_d   = RSEL_W'(instr_reg(32'(instr_q), PC_W, RSEL_W));
        addr_d   = PC_W'(instr_addr(32'(instr_q), PC_W));
        pc_inc_d = pc_q + PC_W'(1);
        step_d   = step_q + SC_W'(1);
        case (op_d)
            OP_JZ:   pc_d = zero[rsel_d] ? addr_d : pc_inc_d;
            OP_HALT: pc_d = pc_q;
            default: pc_d = pc_inc_d;
        endcase
    end

    assign reg_op_en = (state_q == ST_EXEC) && ((op_d == OP_INC) || (op_d == OP_DEC));

    paper_processor_gen_regfile #(
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .we_i     (bus.reg_we && cfg_ok),
        .wsel_i   (bus.reg_sel),
        .wdata_i  (bus.reg_wdata),
        .op_en_i  (reg_op_en),
        .op_dec_i (op_d == OP_DEC),
        .op_sel_i (rsel_d),
        .rsel_i   (bus.reg_sel),
        .rdata_o  (rdata),
        .zero_o   (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            step_q    <= '0;
            timeout_q <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q   <= ST_FETCH;
                        pc_q      <= '0;
                        step_q    <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    instr_q <= mem_q[pc_q];
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    step_q <= step_d;
                    pc_q   <= pc_d;
                    // HALT takes precedence over the step limit on the same step.
                    if (op_d == OP_HALT) begin
                        state_q   <= ST_DONE;
                        timeout_q <= 1'b0;
                    end else if (step_d == SC_W'(MAX_STEPS)) begin
                        state_q   <= ST_DONE;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.timeout     = timeout_q;
    assign bus.pc          = pc_q;
    assign bus.state       = state_q;
    assign bus.instruction = instr_q;
    assign bus.step_count  = step_q;
    assign bus.reg_rdata   = rdata;

endmodule

// File: tb/tb_paper_processor_gen.sv
// Scoreboard bench for paper_processor_gen: an abstract program interpreter predicts
// each run's outcome; a monitor compares when done rises.
module tb_paper_processor_gen;
    import paper_processor_gen_pkg::*;

    localparam int REG_W     = 4;
    localparam int NUM_REGS  = 4;
    localparam int PC_W      = 4;
    localparam int MAX_STEPS = 255;
    localparam int DEPTH     = 16;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;

    always #5 clk = ~clk;

    paper_processor_gen_if #(.REG_W(REG_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W), .MAX_STEPS(MAX_STEPS)) bus ();
    paper_processor_gen_if #(.REG_W(REG_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W), .MAX_STEPS(8)) bus8 ();

    paper_processor_gen #(.REG_W(REG_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W), .MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .bus(bus)
    );

    paper_processor_gen #(.REG_W(REG_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W), .MAX_STEPS(8)) dut8 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .bus(bus8)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned pc;
        int unsigned steps;
        int unsigned timeout;
        int unsigned cycles;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  prog_m [DEPTH];
    int unsigned regs_m [NUM_REGS];

    function automatic logic [7:0] enc(input logic [1:0] op, input int unsigned r, input int unsigned a);
        logic [7:0] w;
        w = {op, 2'(r), 4'(a)};
        return w;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Interpreter over prog_m/regs_m: one loop iteration per executed instruction.
    function automatic void model_run(input int unsigned max_steps, output exp_t e);
        int unsigned pc = 0;
        int unsigned steps = 0;
        bit halted = 1'b0;
        logic [7:0] w;
        int unsigned op, r, a;
        while (!halted && steps < max_steps) begin
            w = prog_m[pc];
            op = 32'(w[7:6]);
            r  = 32'(w[5:4]);
            a  = 32'(w[3:0]);
            steps++;
            if (op == 3) begin
                halted = 1'b1;
            end else if (op == 0) begin
                regs_m[r] = (regs_m[r] + 1) % 16;
                pc = (pc + 1) % 16;
            end else if (op == 1) begin
                if (regs_m[r] != 0) regs_m[r] = regs_m[r] - 1;
                pc = (pc + 1) % 16;
            end else begin
                pc = (regs_m[r] == 0) ? a : (pc + 1) % 16;
            end
        end
        e.pc = pc;
        e.steps = steps;
        e.timeout = halted ? 0 : 1;
        e.cycles = 2 * steps;
    endfunction

    // Monitor: counts busy cycles and checks each completed run against the queue.
    logic        done_prev = 1'b0;
    int unsigned busy_cnt = 0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        else if (!bus.done) busy_cnt = 0;
        if (!reset && bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected_done: done rose with no run expected");
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_pc", 32'(bus.pc), mon_e.pc);
                chk("sb_steps", 32'(bus.step_count), mon_e.steps);
                chk("sb_timeout", 32'(bus.timeout), mon_e.timeout);
                chk("sb_busy_cycles", busy_cnt, mon_e.cycles);
            end
            busy_cnt = 0;
        end
        done_prev = bus.done;
    end

    task automatic load_prog();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus.prog_we = 1'b1;
            bus.prog_addr = 4'(i);
            bus.prog_data = prog_m[i];
            @(negedge clk);
        end
        bus.prog_we = 1'b0;
    endtask

    task automatic preload(input int unsigned sel, input int unsigned val);
        bus.reg_we = 1'b1;
        bus.reg_sel = 2'(sel);
        bus.reg_wdata = 4'(val);
        @(negedge clk);
        bus.reg_we = 1'b0;
        regs_m[sel] = val;
    endtask

    task automatic check_regs(input string tag);
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            bus.reg_sel = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(bus.reg_rdata), regs_m[i]);
        end
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 1);
    endtask

    task automatic run(input string tag, input int unsigned stall, input bit poke);
        exp_t e;
        model_run(MAX_STEPS, e);
        e.cycles += stall;
        exp_q.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (stall > 0 || poke) begin
            repeat (3) @(negedge clk);
            if (poke) begin
                bus.prog_we = 1'b1;
                bus.prog_addr = 4'd4;
                bus.prog_data = enc(OP_INC, 0, 0);
                bus.reg_we = 1'b1;
                bus.reg_sel = 2'd1;
                bus.reg_wdata = 4'd9;
                bus.start = 1'b1;
                @(negedge clk);
                bus.prog_we = 1'b0;
                bus.reg_we = 1'b0;
                bus.start = 1'b0;
            end
            if (stall > 0) begin
                clk_en = 1'b0;
                repeat (stall) @(negedge clk);
                clk_en = 1'b1;
            end
        end
        wait_done(tag, 600 + stall);
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic run8(input string tag, input int unsigned e_pc, input int unsigned e_to);
        int unsigned n = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus8.prog_we = 1'b1;
            bus8.prog_addr = 4'(i);
            bus8.prog_data = prog_m[i];
            @(negedge clk);
        end
        bus8.prog_we = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        while (!bus8.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(bus8.done), 1);
        chk({tag, "_steps"}, 32'(bus8.step_count), 8);
        chk({tag, "_pc"}, 32'(bus8.pc), e_pc);
        chk({tag, "_timeout"}, 32'(bus8.timeout), e_to);
    endtask

    task automatic fill_prog(input logic [7:0] w);
        for (int unsigned i = 0; i < DEPTH; i++) prog_m[i] = w;
    endtask

    initial begin
        int unsigned n;
        bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.reg_we = 1'b0; bus.reg_sel = '0; bus.reg_wdata = '0;
        bus8.start = 1'b0; bus8.prog_we = 1'b0; bus8.prog_addr = '0; bus8.prog_data = '0;
        bus8.reg_we = 1'b0; bus8.reg_sel = '0; bus8.reg_wdata = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_m[i] = 0;
        clk_en = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_state", 32'(bus.state), 0);
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_steps", 32'(bus.step_count), 0);
        check_regs("rst");

        // Add loop: r1 += r0
        fill_prog(enc(OP_HALT, 0, 0));
        prog_m[0] = enc(OP_JZ, 0, 4);
        prog_m[1] = enc(OP_DEC, 0, 0);
        prog_m[2] = enc(OP_INC, 1, 0);
        prog_m[3] = enc(OP_JZ, 2, 0);
        load_prog();
        preload(0, 3); preload(1, 2); preload(2, 0);
        run("add", 0, 1'b0);
        chk("add_steps_const", 32'(bus.step_count), 14);
        chk("add_pc_const", 32'(bus.pc), 4);
        bus.reg_sel = 2'd1; #1;
        chk("add_r1_const", 32'(bus.reg_rdata), 5);
        @(negedge clk);

        preload(0, 3); preload(1, 2);
        run("poke", 0, 1'b1);
        preload(0, 3); preload(1, 2);
        run("stall", 5, 1'b0);

        // Reset during EXEC of INC r1 aborts the writeback and clears the registers.
        preload(0, 3); preload(1, 2);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.state == 2'd2 && bus.instruction == enc(OP_INC, 1, 0)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst6_exec_inc_seen", 32'(bus.instruction), 32'(enc(OP_INC, 1, 0)));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_m[i] = 0;
        chk("rst6_state", 32'(bus.state), 0);
        chk("rst6_busy", 32'(bus.busy), 0);
        check_regs("rst6");
        preload(0, 3); preload(1, 2);
        run("rerun", 0, 1'b0);

        // Wrap/saturate boundaries and pc wrap from 15 to 0
        fill_prog(enc(OP_HALT, 0, 0));
        prog_m[0]  = enc(OP_JZ, 2, 2);
        prog_m[2]  = enc(OP_INC, 0, 0);
        prog_m[3]  = enc(OP_DEC, 1, 0);
        prog_m[4]  = enc(OP_JZ, 1, 15);
        prog_m[15] = enc(OP_INC, 2, 0);
        load_prog();
        preload(0, 15); preload(1, 0); preload(2, 0); preload(3, 0);
        run("bound", 0, 1'b0);
        chk("bound_steps_const", 32'(bus.step_count), 7);
        bus.reg_sel = 2'd0; #1;
        chk("bound_r0_const", 32'(bus.reg_rdata), 0);
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            for (int unsigned i = 0; i < DEPTH; i++) prog_m[i] = 8'($urandom);
            load_prog();
            for (int unsigned i = 0; i < NUM_REGS; i++) preload(i, $urandom_range(0, 15));
            run($sformatf("rnd%0d", k), 0, 1'b0);
        end

        fill_prog(enc(OP_JZ, 0, 0));
        run8("lim_loop", 0, 1);
        fill_prog(enc(OP_HALT, 0, 0));
        for (int unsigned i = 0; i < 7; i++) prog_m[i] = enc(OP_INC, 1, 0);
        run8("lim_halt", 7, 0);
        prog_m[7] = enc(OP_INC, 1, 0);
        run8("lim_inc", 8, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
